// File: rtl/uart_rx_pkt_ctrl.sv
// uart_rx_pkt_ctrl: turns UART receiver byte strobes into checked packets (A5, LEN, payload, CHK).
// Latency: a packet is valid one Clk after the CHK byte edge; error pulses come one Clk after their cause.
// Backpressure: a held packet blocks reception until pkt_ack; bytes arriving meanwhile are dropped with err_ovr.
//
// Ports:
//   Clk, Rst_n (sync, active-high), En        - clock, reset, controller enable
//   RxDone, RxData                            - byte-done level and byte from the UART receiver
//   Tick, RxEn, NBits                         - oversample strobe, enable and word length to the receiver
//   pkt_valid, pkt_len, pkt_ack               - held-packet status and release
//   rd_addr, rd_data                          - combinational payload buffer read port
//   err_chk, err_len, err_tmo, err_ovr        - one-cycle error pulses
module uart_rx_pkt_ctrl #(
  parameter int TICK_DIV = 326,
  parameter int TIMEOUT  = 50000
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       En,
  input  logic       RxDone,
  input  logic [7:0] RxData,
  input  logic       pkt_ack,
  input  logic [3:0] rd_addr,
  output logic       Tick,
  output logic       RxEn,
  output logic [3:0] NBits,
  output logic       pkt_valid,
  output logic [4:0] pkt_len,
  output logic [7:0] rd_data,
  output logic       err_chk,
  output logic       err_len,
  output logic       err_tmo,
  output logic       err_ovr
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int OW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CHK, S_HOLD} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tick_cnt;
  logic [OW-1:0] tmo_cnt;
  logic          rxdone_q;
  logic          byte_evt;
  logic [7:0]    sum;
  logic [3:0]    idx;
  logic [7:0]    pkt_buf [16];
  logic          ld_len, ld_data, tmo_hit;
  logic          err_chk_nxt, err_len_nxt, err_tmo_nxt, err_ovr_nxt;

  // Only the first cycle of a RxDone high level counts as a byte.
  assign byte_evt  = RxDone & ~rxdone_q;
  // The count would reach TIMEOUT on the coming edge.
  assign tmo_hit   = (tmo_cnt == OW'(TIMEOUT - 1));
  assign pkt_valid = (state == S_HOLD);
  assign NBits     = 4'd8;
  assign rd_data   = pkt_buf[rd_addr];

  always_comb begin
    state_nxt   = state;
    ld_len      = 1'b0;
    ld_data     = 1'b0;
    err_chk_nxt = 1'b0;
    err_len_nxt = 1'b0;
    err_tmo_nxt = 1'b0;
    err_ovr_nxt = 1'b0;
    if (!En) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (byte_evt && RxData == 8'hA5) state_nxt = S_LEN;
        S_LEN: begin
          if (byte_evt) begin
            if (RxData != 8'd0 && RxData <= 8'd16) begin
              ld_len    = 1'b1;
              state_nxt = S_DATA;
            end else begin
              err_len_nxt = 1'b1;
              state_nxt   = S_IDLE;
            end
          end else if (tmo_hit) begin
            err_tmo_nxt = 1'b1;
            state_nxt   = S_IDLE;
          end
        end
        S_DATA: begin
          if (byte_evt) begin
            ld_data = 1'b1;
            if ({1'b0, idx} == pkt_len - 5'd1) state_nxt = S_CHK;
          end else if (tmo_hit) begin
            err_tmo_nxt = 1'b1;
            state_nxt   = S_IDLE;
          end
        end
        S_CHK: begin
          if (byte_evt) begin
            if (RxData == sum) begin
              state_nxt = S_HOLD;
            end else begin
              err_chk_nxt = 1'b1;
              state_nxt   = S_IDLE;
            end
          end else if (tmo_hit) begin
            err_tmo_nxt = 1'b1;
            state_nxt   = S_IDLE;
          end
        end
        S_HOLD: begin
          // The ack releases the packet even when a byte lands in the same cycle; that byte is lost.
          if (byte_evt) err_ovr_nxt = 1'b1;
          if (pkt_ack)  state_nxt   = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst_n) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      Tick     <= 1'b0;
      RxEn     <= 1'b0;
      rxdone_q <= 1'b0;
      pkt_len  <= '0;
      sum      <= '0;
      idx      <= '0;
      tmo_cnt  <= '0;
      err_chk  <= 1'b0;
      err_len  <= 1'b0;
      err_tmo  <= 1'b0;
      err_ovr  <= 1'b0;
    end else begin
      Tick     <= (tick_cnt == TW'(TICK_DIV - 1));
      tick_cnt <= (tick_cnt == TW'(TICK_DIV - 1)) ? '0 : tick_cnt + TW'(1);
      RxEn     <= En;
      rxdone_q <= RxDone;
      state    <= state_nxt;
      err_chk  <= err_chk_nxt;
      err_len  <= err_len_nxt;
      err_tmo  <= err_tmo_nxt;
      err_ovr  <= err_ovr_nxt;
      if (ld_len) begin
        pkt_len <= RxData[4:0];
        sum     <= RxData;
        idx     <= '0;
      end
      if (ld_data) begin
        sum <= sum + RxData;
        idx <= idx + 4'd1;
      end
      // Idle timer runs only inside a packet and restarts on every byte and state change.
      if (byte_evt || state_nxt != state || state == S_IDLE || state == S_HOLD)
        tmo_cnt <= '0;
      else if (tmo_cnt != OW'(TIMEOUT))
        tmo_cnt <= tmo_cnt + OW'(1);
    end
  end

  // Payload storage carries no reset; it is only meaningful while a packet is held.
  always_ff @(posedge Clk) begin
    if (ld_data) pkt_buf[idx] <= RxData;
  end

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
module tb_uart_rx_pkt_ctrl;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b1;
  logic       En = 1'b0;
  logic       RxDone = 1'b0;
  logic [7:0] RxData = 8'h00;
  logic       pkt_ack = 1'b0;
  logic [3:0] rd_addr = 4'd0;
  logic       Tick, RxEn, pkt_valid;
  logic [3:0] NBits;
  logic [4:0] pkt_len;
  logic [7:0] rd_data;
  logic       err_chk, err_len, err_tmo, err_ovr;

  uart_rx_pkt_ctrl #(.TICK_DIV(4), .TIMEOUT(100)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .En(En), .RxDone(RxDone), .RxData(RxData),
    .pkt_ack(pkt_ack), .rd_addr(rd_addr), .Tick(Tick), .RxEn(RxEn), .NBits(NBits),
    .pkt_valid(pkt_valid), .pkt_len(pkt_len), .rd_data(rd_data),
    .err_chk(err_chk), .err_len(err_len), .err_tmo(err_tmo), .err_ovr(err_ovr)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;
  logic chk_on = 1'b0;

  // Packet-level model: bytes of the frame in progress, the held packet, expected pulses.
  logic [7:0] frame [$];
  logic       m_en = 1'b0;
  logic       m_hold = 1'b0;
  logic [4:0] exp_len = 5'd0;
  logic [7:0] exp_buf [16];
  logic       exp_rxen = 1'b0;
  logic       exp_err_chk = 1'b0, exp_err_len = 1'b0, exp_err_tmo = 1'b0, exp_err_ovr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    int s;
    int n;
    if (!m_en) return;
    if (m_hold) begin
      exp_err_ovr = 1'b1;
      return;
    end
    frame.push_back(b);
    n = frame.size();
    if (frame[0] != 8'hA5) begin
      frame.delete();
    end else if (n == 2) begin
      if (frame[1] == 8'd0 || frame[1] > 8'd16) begin
        exp_err_len = 1'b1;
        frame.delete();
      end
    end else if (n > 2 && n == int'(frame[1]) + 3) begin
      s = 0;
      for (int i = 1; i <= int'(frame[1]) + 1; i++) s += int'(frame[i]);
      if ((s % 256) == int'(b)) begin
        m_hold  = 1'b1;
        exp_len = frame[1][4:0];
        for (int i = 0; i < int'(frame[1]); i++) exp_buf[i] = frame[i + 2];
      end else begin
        exp_err_chk = 1'b1;
      end
      frame.delete();
    end
  endtask

  task automatic clr_pulses();
    exp_err_chk = 1'b0;
    exp_err_len = 1'b0;
    exp_err_tmo = 1'b0;
    exp_err_ovr = 1'b0;
  endtask

  // Every stimulus task starts and ends 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b);
    RxData = b;
    RxDone = 1'b1;
    @(posedge Clk); model_byte(b);
    @(posedge Clk); clr_pulses();
    @(posedge Clk); #1 RxDone = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic send_bytes(input logic [7:0] bs [$]);
    foreach (bs[i]) send_byte(bs[i]);
  endtask

  task automatic send_byte_ack(input logic [7:0] b);
    RxData = b;
    RxDone = 1'b1;
    pkt_ack = 1'b1;
    @(posedge Clk);
    if (m_hold) exp_err_ovr = 1'b1;
    m_hold = 1'b0;
    #1 pkt_ack = 1'b0;
    @(posedge Clk); clr_pulses();
    @(posedge Clk); #1 RxDone = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic ack();
    pkt_ack = 1'b1;
    @(posedge Clk); m_hold = 1'b0;
    #1 pkt_ack = 1'b0;
  endtask

  task automatic set_en(input logic v);
    En = v;
    @(posedge Clk);
    exp_rxen = v;
    m_en = v;
    if (!v) begin
      frame.delete();
      m_hold = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    Rst_n = 1'b1;
    @(posedge Clk);
    frame.delete();
    m_hold = 1'b0;
    exp_rxen = 1'b0;
    clr_pulses();
    chk_on = 1'b1;
    #1 chk("tick_in_reset", Tick, 1'b0);
    repeat (2) @(posedge Clk);
    #1 Rst_n = 1'b0;
    // Tick is high on the 4th, 8th and 12th edge after the last reset edge.
    for (int k = 1; k <= 12; k++) begin
      @(posedge Clk);
      if (k == 1) exp_rxen = En;
      #1 chk("tick_period", Tick, (k % 4 == 0) ? 1'b1 : 1'b0);
    end
  endtask

  task automatic check_payload(input string name);
    for (int i = 0; i < int'(exp_len); i++) begin
      rd_addr = 4'(i);
      @(negedge Clk);
      chk(name, rd_data, exp_buf[i]);
    end
    @(posedge Clk); #1;
  endtask

  always @(negedge Clk) begin
    if (chk_on) begin
      chk("pkt_valid", pkt_valid, m_hold);
      if (m_hold) chk("pkt_len", pkt_len, exp_len);
      chk("err_chk", err_chk, exp_err_chk);
      chk("err_len", err_len, exp_err_len);
      chk("err_tmo", err_tmo, exp_err_tmo);
      chk("err_ovr", err_ovr, exp_err_ovr);
      chk("rxen", RxEn, exp_rxen);
      chk("nbits", NBits, 4'd8);
    end
  end

  initial begin
    do_reset();
    set_en(1'b1);

    // Checksum covers LEN plus payload: 03+11+22+33 = 69.
    send_bytes('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69});
    chk("lit_valid_a", pkt_valid, 1'b1);
    chk("lit_len_a", pkt_len, 5'd3);
    rd_addr = 4'd0; #1 chk("lit_rd0", rd_data, 8'h11);
    rd_addr = 4'd1; #1 chk("lit_rd1", rd_data, 8'h22);
    rd_addr = 4'd2; #1 chk("lit_rd2", rd_data, 8'h33);
    @(posedge Clk); #1;
    check_payload("payload_a");
    ack();
    chk("lit_ack_clears", pkt_valid, 1'b0);

    // Bad checksum, then a good one-byte packet (01+7F = 80).
    send_bytes('{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00});
    chk("lit_valid_badchk", pkt_valid, 1'b0);
    send_bytes('{8'hA5, 8'h01, 8'h7F, 8'h80});
    chk("lit_len_b", pkt_len, 5'd1);
    rd_addr = 4'd0; #1 chk("lit_rd_b", rd_data, 8'h7F);
    @(posedge Clk); #1;
    ack();

    // Length errors, stray byte ignored in idle.
    send_bytes('{8'hA5, 8'h00});
    send_bytes('{8'hA5, 8'h11});
    send_bytes('{8'h55, 8'hA5, 8'h01, 8'h01, 8'h02});
    chk("lit_valid_c", pkt_valid, 1'b1);

    // Overrun while held, then byte and ack in the same cycle.
    send_byte(8'h33);
    chk("lit_still_held", pkt_valid, 1'b1);
    send_byte_ack(8'h5A);
    chk("lit_ack_wins", pkt_valid, 1'b0);

    // Timeout: err_tmo comes 100 edges after the edge that captured AA.
    send_bytes('{8'hA5, 8'h04});
    send_byte(8'hAA);
    repeat (97) @(posedge Clk);
    exp_err_tmo = 1'b1;
    frame.delete();
    @(negedge Clk) chk("lit_tmo", err_tmo, 1'b1);
    @(posedge Clk); exp_err_tmo = 1'b0;
    #1;
    send_byte(8'h01);
    send_bytes('{8'hA5, 8'h01, 8'h05, 8'h06});
    chk("lit_after_tmo", pkt_valid, 1'b1);
    ack();

    // Enable dropped mid-payload aborts silently.
    send_bytes('{8'hA5, 8'h02, 8'h44});
    set_en(1'b0);
    repeat (3) @(posedge Clk);
    #1;
    set_en(1'b1);
    send_bytes('{8'h55, 8'hA5, 8'h01, 8'h09, 8'h0A});
    chk("lit_after_en", pkt_valid, 1'b1);
    ack();

    // Reset mid-packet: the rest of the old frame is treated from idle.
    send_bytes('{8'hA5, 8'h03, 8'h01});
    do_reset();
    send_bytes('{8'h02, 8'h03, 8'h09});
    chk("lit_after_rst", pkt_valid, 1'b0);
    send_bytes('{8'hA5, 8'h02, 8'h01, 8'h02, 8'h05});
    ack();

    // Maximum length: 16 + (0+1+..+15) = 136 = 0x88.
    send_bytes('{8'hA5, 8'h10});
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    send_byte(8'h88);
    chk("lit_len16", pkt_len, 5'd16);
    check_payload("payload_16");
    ack();
    repeat (3) @(posedge Clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
